// File: rtl/siso8_pkg.sv
// Shared types and constants for the siso8 serializer slice.
// The optional parity bit is enabled by defining SISO8_PARITY_EN.
package siso8_pkg;

    localparam int SISO8_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } siso8_state_e;

    // Bit-index counter width; guarded so a degenerate width still gets one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/siso8_serializer_if.sv
// Upstream word handshake plus serial output bundle of the siso8 serializer.
// master = the environment driving words and SHIFT_EN, slave = the serializer.
interface siso8_serializer_if #(
    parameter int WIDTH = siso8_pkg::SISO8_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             ser_d;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output in_data, in_valid, shift_en,
        input  in_ready, ser_d, ser_valid, busy, done
    );

    modport slave (
        input  in_data, in_valid, shift_en,
        output in_ready, ser_d, ser_valid, busy, done
    );

endinterface

// File: rtl/siso8_bitcnt.sv
// Load/advance bit counter with a last-position flag, shared with the deserializer.
// The count saturates at WIDTH-1 and restarts only on load or reset.
module siso8_bitcnt
    import siso8_pkg::*;
#(
    parameter int WIDTH = SISO8_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic advance,
    output logic last
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] count;

    // Load wins over advance so a back-to-back word restarts at bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (advance && !last) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/siso8_serializer.sv
// Parallel-to-serial front end feeding the D input of the 8-stage SISO chain.
// Define SISO8_PARITY_EN to append an even-parity bit after each word.
module siso8_serializer
    import siso8_pkg::*;
#(
    parameter int WIDTH     = SISO8_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic               clk,
    input logic               reset,
    siso8_serializer_if.slave bus
);

    siso8_state_e     state;
    siso8_state_e     state_next;
    logic [WIDTH-1:0] shreg;
    logic             bit_last;
    logic             accept;
    logic             advance;
    logic             data_advance;
    logic             last_out;
    logic             done_q;
    logic             done_next;
    logic             head_bit;
`ifdef SISO8_PARITY_EN
    logic             parity;
`endif

    assign head_bit     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign bus.ser_valid = (state != IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

`ifdef SISO8_PARITY_EN
    assign last_out  = (state == PAR);
    assign bus.ser_d = (state == SHIFT) ? head_bit : ((state == PAR) ? parity : 1'b0);
`else
    assign last_out  = (state == SHIFT) && bit_last;
    assign bus.ser_d = (state == SHIFT) && head_bit;
`endif

    // Ready opens during the final consume so the next word follows without a bubble.
    assign bus.in_ready = !reset && ((state == IDLE) || (last_out && bus.shift_en));
    assign accept       = bus.in_valid && bus.in_ready;
    assign advance      = bus.ser_valid && bus.shift_en;
    assign data_advance = advance && (state == SHIFT);

    siso8_bitcnt #(
        .WIDTH(WIDTH)
    ) u_bitcnt (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .advance(data_advance),
        .last   (bit_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (data_advance && bit_last) begin
`ifdef SISO8_PARITY_EN
                    state_next = PAR;
`else
                    state_next = accept ? SHIFT : IDLE;
                    done_next  = 1'b1;
`endif
                end
            end
`ifdef SISO8_PARITY_EN
            PAR: begin
                if (advance) begin
                    state_next = accept ? SHIFT : IDLE;
                    done_next  = 1'b1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shifting moves the next bit into the output position chosen by MSB_FIRST.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg  <= '0;
`ifdef SISO8_PARITY_EN
            parity <= 1'b0;
`endif
        end else if (accept) begin
            shreg  <= bus.in_data;
`ifdef SISO8_PARITY_EN
            parity <= ^bus.in_data;
`endif
        end else if (data_advance) begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        end
    end

endmodule
